// File: rtl/bus_initiator_if.sv
// Client command/result and femto bus signals of one bus initiator.
// master: the initiator's view (accepts commands, drives the bus).
// slave:  the client + responder view (issues commands, answers the bus).
interface bus_initiator_if #(
  parameter int VA_WIDTH  = 32,
  parameter int BUS_WIDTH = 32,
  parameter int ACC_WIDTH = 2
);
  // client command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [VA_WIDTH-1:0]  cmd_addr;
  logic                 cmd_w_rb;
  logic [ACC_WIDTH-1:0] cmd_acc;
  logic [BUS_WIDTH-1:0] cmd_wdata;
  // client result channel
  logic                 rsp_valid;
  logic [1:0]           rsp_err;
  logic [BUS_WIDTH-1:0] rsp_rdata;
  // femto bus
  logic [VA_WIDTH-1:0]  addr;
  logic                 w_rb;
  logic [ACC_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0] wdata;
  logic                 req;
  logic [BUS_WIDTH-1:0] rdata;
  logic                 resp;
  logic                 fault;

  modport master (
    input  cmd_valid, cmd_addr, cmd_w_rb, cmd_acc, cmd_wdata,
    input  rdata, resp, fault,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output addr, w_rb, acc, wdata, req
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_w_rb, cmd_acc, cmd_wdata,
    output rdata, resp, fault,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  addr, w_rb, acc, wdata, req
  );
endinterface

// File: rtl/bus_initiator.sv
// Femto bus initiator: runs one client command as a single bus transfer and
// returns a one-cycle result (ok / fault / timeout).
// Ports: clk, rst (async active-high), bif (bus_initiator_if.master: command,
// result and bus signals). Nominal: accept N, req N+1, resp N+2, result N+3.
module bus_initiator #(
  parameter int VA_WIDTH  = 32,
  parameter int BUS_WIDTH = 32,
  parameter int ACC_WIDTH = 2,
  parameter int TIMEOUT   = 16   // wait cycles after req, 2..255
) (
  input  logic             clk,
  input  logic             rst,
  bus_initiator_if.master  bif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FAULT   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

  state_t               state;
  logic [7:0]           cnt;
  logic                 req_q;
  logic                 rsp_valid_q;
  logic [1:0]           rsp_err_q;
  logic [BUS_WIDTH-1:0] rsp_rdata_q;
  logic [VA_WIDTH-1:0]  addr_q;
  logic                 w_rb_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [BUS_WIDTH-1:0] wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      w_rb_q      <= 1'b0;
      acc_q       <= '0;
      wdata_q     <= '0;
    end else begin
      // req and rsp_valid are single-cycle strobes, raised only on entry
      // to REQ and DONE respectively.
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bif.cmd_valid) begin
            addr_q  <= bif.cmd_addr;
            w_rb_q  <= bif.cmd_w_rb;
            acc_q   <= bif.cmd_acc;
            wdata_q <= bif.cmd_wdata;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Responders reject combinationally in the req cycle; resp is
          // never looked at here.
          if (bif.fault) begin
            rsp_err_q   <= ERR_FAULT;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // resp is checked before the timeout so a completion on the last
          // wait cycle still counts as ok. fault is ignored here.
          if (bif.resp) begin
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= w_rb_q ? '0 : bif.rdata;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else if (cnt == CNT_LAST) begin
            rsp_err_q   <= ERR_TIMEOUT;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bif.cmd_ready = (state == IDLE);
  assign bif.req       = req_q;
  assign bif.rsp_valid = rsp_valid_q;
  assign bif.rsp_err   = rsp_err_q;
  assign bif.rsp_rdata = rsp_rdata_q;
  assign bif.addr      = addr_q;
  assign bif.w_rb      = w_rb_q;
  assign bif.acc       = acc_q;
  assign bif.wdata     = wdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed cases plus randomized
// transfers scored against a transfer-level model of latency/result.
// Drives and samples on the falling clock edge.
module tb_bus_initiator;

  localparam int VA_WIDTH  = 32;
  localparam int BUS_WIDTH = 32;
  localparam int ACC_WIDTH = 2;
  localparam int TIMEOUT   = 16;

  localparam int M_RESP  = 0;  // responder answers k cycles after req
  localparam int M_FAULT = 1;  // responder rejects in the req cycle

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_initiator_if #(
    .VA_WIDTH (VA_WIDTH),
    .BUS_WIDTH(BUS_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) bif ();

  bus_initiator #(
    .VA_WIDTH (VA_WIDTH),
    .BUS_WIDTH(BUS_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bif(bif)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer. mode/k describe the responder; noise injects ignored
  // faults during the wait phase. Expected result comes from the rules:
  // fault -> result 1 cycle after req, err 01; resp on wait cycle k
  // (1..TIMEOUT) -> result k+1 cycles after req, err 00; otherwise
  // result TIMEOUT+1 cycles after req, err 10.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [1:0] ac,
                      input logic [31:0] wd, input int mode, input int k,
                      input logic [31:0] rd, input bit noise);
    int exp_lat;
    logic [1:0] exp_err;
    logic [31:0] exp_rd;
    int cyc;
    bit got;
    if (mode == M_FAULT) begin
      exp_lat = 1; exp_err = 2'b01;
    end else if (k >= 1 && k <= TIMEOUT) begin
      exp_lat = k + 1; exp_err = 2'b00;
    end else begin
      exp_lat = TIMEOUT + 1; exp_err = 2'b10;
    end
    exp_rd = (exp_err == 2'b00 && !w) ? rd : 32'h0;

    chk("idle_ready", {63'b0, bif.cmd_ready}, 64'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = a;
    bif.cmd_w_rb  = w;
    bif.cmd_acc   = ac;
    bif.cmd_wdata = wd;
    @(negedge clk);
    // Garbage on the command port while busy must be ignored.
    bif.cmd_valid = 1'b0;
    bif.cmd_addr  = $urandom;
    bif.cmd_w_rb  = 1'($urandom);
    bif.cmd_acc   = 2'($urandom);
    bif.cmd_wdata = $urandom;
    chk("bus_addr", {32'b0, bif.addr}, {32'b0, a});
    chk("bus_w_rb", {63'b0, bif.w_rb}, {63'b0, w});
    chk("bus_acc", {62'b0, bif.acc}, {62'b0, ac});
    chk("bus_wdata", {32'b0, bif.wdata}, {32'b0, wd});

    cyc = 0;
    got = 0;
    while (!got && cyc <= TIMEOUT + 4) begin
      if (bif.rsp_valid) begin
        got = 1;
      end else begin
        chk("req_pulse", {63'b0, bif.req}, {63'b0, (cyc == 0)});
        chk("busy_ready", {63'b0, bif.cmd_ready}, 64'd0);
        bif.fault = (mode == M_FAULT && cyc == 0) ||
                    (noise && cyc > 0 && $urandom_range(0, 2) == 0);
        bif.resp  = (mode == M_RESP && cyc == k);
        bif.rdata = bif.resp ? rd : $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    bif.fault = 1'b0;
    bif.resp  = 1'b0;
    if (!got) chk("rsp_seen", 64'd0, 64'd1);
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("rsp_err", {62'b0, bif.rsp_err}, {62'b0, exp_err});
    chk("rsp_rdata", {32'b0, bif.rsp_rdata}, {32'b0, exp_rd});
    chk("addr_stable", {32'b0, bif.addr}, {32'b0, a});
    @(negedge clk);
    chk("rsp_one_cycle", {63'b0, bif.rsp_valid}, 64'd0);
    chk("ready_again", {63'b0, bif.cmd_ready}, 64'd1);
    chk("rdata_hold", {32'b0, bif.rsp_rdata}, {32'b0, exp_rd});
  endtask

  initial begin
    logic [31:0] d [2];
    bif.cmd_valid = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_w_rb  = 1'b0;
    bif.cmd_acc   = '0;
    bif.cmd_wdata = '0;
    bif.rdata     = '0;
    bif.resp      = 1'b0;
    bif.fault     = 1'b0;

    // Reset state, with a stray command present during reset.
    bif.cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", {63'b0, bif.req}, 64'd0);
    chk("rst_rsp_valid", {63'b0, bif.rsp_valid}, 64'd0);
    chk("rst_rsp_err", {62'b0, bif.rsp_err}, 64'd0);
    chk("rst_rdata", {32'b0, bif.rsp_rdata}, 64'd0);
    chk("rst_addr", {32'b0, bif.addr}, 64'd0);
    chk("rst_ready", {63'b0, bif.cmd_ready}, 64'd1);
    bif.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {63'b0, bif.req}, 64'd0);

    // Directed cases.
    xfer(32'h1000, 1'b0, 2'd2, 32'h0, M_RESP, 1, 32'hDEADBEEF, 0);
    xfer(32'h2004, 1'b1, 2'd2, 32'h5, M_RESP, 1, 32'hCAFEF00D, 0);
    xfer(32'h3000, 1'b0, 2'd0, 32'h0, M_FAULT, 0, 32'h12345678, 0);
    xfer(32'h4000, 1'b0, 2'd2, 32'h0, M_RESP, TIMEOUT + 3, 32'h1, 0);
    xfer(32'h4004, 1'b0, 2'd1, 32'h0, M_RESP, TIMEOUT, 32'hA5A55A5A, 0);
    xfer(32'h4008, 1'b0, 2'd1, 32'h0, M_RESP, 0, 32'h77, 0);  // resp in req cycle ignored

    // Stray resp/fault while idle: no result, still ready.
    bif.resp = 1'b1; bif.fault = 1'b1;
    @(negedge clk);
    bif.resp = 1'b0; bif.fault = 1'b0;
    chk("stray_idle_rsp", {63'b0, bif.rsp_valid}, 64'd0);
    chk("stray_idle_ready", {63'b0, bif.cmd_ready}, 64'd1);

    // Back-to-back with cmd_valid held: period of 4 cycles per transfer.
    d[0] = $urandom;
    d[1] = $urandom;
    bif.cmd_valid = 1'b1;
    bif.cmd_w_rb  = 1'b0;
    bif.cmd_addr  = 32'h5000;
    for (int c = 0; c < 8; c++) begin
      chk("b2b_ready", {63'b0, bif.cmd_ready}, {63'b0, (c % 4 == 0)});
      chk("b2b_req", {63'b0, bif.req}, {63'b0, (c % 4 == 1)});
      chk("b2b_rsp", {63'b0, bif.rsp_valid}, {63'b0, (c % 4 == 3)});
      if (c % 4 == 3) chk("b2b_rdata", {32'b0, bif.rsp_rdata}, {32'b0, d[c / 4]});
      // resp is stray in IDLE (c%4==0) and DONE (c%4==3).
      bif.resp  = (c % 4 != 1);
      bif.rdata = (c % 4 == 2) ? d[c / 4] : $urandom;
      if (c == 7) bif.cmd_valid = 1'b0;
      @(negedge clk);
    end
    bif.resp = 1'b0;
    chk("b2b_tail_ready", {63'b0, bif.cmd_ready}, 64'd1);
    chk("b2b_tail_rsp", {63'b0, bif.rsp_valid}, 64'd0);

    // Async reset during WAIT, after a fault left rsp_err = 01.
    xfer(32'h6000, 1'b0, 2'd0, 32'h0, M_FAULT, 0, 32'h0, 0);
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h6100;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    chk("pre_rst_req", {63'b0, bif.req}, 64'd1);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_req", {63'b0, bif.req}, 64'd0);
    chk("arst_rsp_valid", {63'b0, bif.rsp_valid}, 64'd0);
    chk("arst_rsp_err", {62'b0, bif.rsp_err}, 64'd0);
    chk("arst_addr", {32'b0, bif.addr}, 64'd0);
    chk("arst_ready", {63'b0, bif.cmd_ready}, 64'd1);
    @(negedge clk);
    bif.resp = 1'b1;
    @(negedge clk);
    bif.resp = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("aborted_no_rsp", {63'b0, bif.rsp_valid}, 64'd0);
    end
    xfer(32'h7000, 1'b0, 2'd2, 32'h0, M_RESP, 1, 32'hBEEF0001, 0);

    // Randomized transfers with ignored-fault noise in the wait phase.
    for (int i = 0; i < 40; i++) begin
      xfer($urandom, 1'($urandom), 2'($urandom), $urandom,
           ($urandom_range(0, 4) == 0) ? M_FAULT : M_RESP,
           int'($urandom_range(1, TIMEOUT + 3)), $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
